// File: rtl/kogge_stone_adder16.sv
// Registered unsigned adder whose carries come from a radix-2 Kogge-Stone prefix tree.
// {carry, s} is the (WIDTH+1)-bit sum of a and b, one clock after the operands are sampled.
module kogge_stone_adder16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             carry
);

    localparam int LEVELS = $clog2(WIDTH);

    // g_lvl[k][i] / p_lvl[k][i]: group generate/propagate of bits i down to i-2^k+1 (clipped at 0).
    logic [WIDTH-1:0] g_lvl [LEVELS+1];
    logic [WIDTH-1:0] p_lvl [LEVELS];

    logic [WIDTH-1:0] sum_next;
    logic             carry_next;

    assign g_lvl[0] = a & b;
    assign p_lvl[0] = a ^ b;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int SPAN = 1 << k;

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
                assign g_lvl[k+1][i] = g_lvl[k][i] | (p_lvl[k][i] & g_lvl[k][i-SPAN]);
                // The last level only feeds the sum XORs and carry, so it never needs P.
                if (k < LEVELS - 1) begin : g_prop
                    assign p_lvl[k+1][i] = p_lvl[k][i] & p_lvl[k][i-SPAN];
                end
            end else begin : g_pass
                assign g_lvl[k+1][i] = g_lvl[k][i];
                if (k < LEVELS - 1) begin : g_prop
                    assign p_lvl[k+1][i] = p_lvl[k][i];
                end
            end
        end
    end

    // Low half of the final-level P feeds no cell; sink it so it is visibly intentional.
    logic unused_final_p;
    assign unused_final_p = ^p_lvl[LEVELS-1][WIDTH/2-1:0];

    assign sum_next[0]         = p_lvl[0][0];
    assign sum_next[WIDTH-1:1] = p_lvl[0][WIDTH-1:1] ^ g_lvl[LEVELS][WIDTH-2:0];
    assign carry_next          = g_lvl[LEVELS][WIDTH-1];

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            carry <= 1'b0;
        end else begin
            s     <= sum_next;
            carry <= carry_next;
        end
    end

endmodule

// File: tb/tb_kogge_stone_adder16.sv
// Self-checking bench for kogge_stone_adder16: directed corners, a small exhaustive block,
// and random back-to-back traffic with mid-stream resets, all compared against plain a+b.
module tb_kogge_stone_adder16;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        carry;

    int checks = 0;
    int errors = 0;

    kogge_stone_adder16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .s     (s),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [16:0] ref_sum(input logic r, input logic [15:0] x, input logic [15:0] y);
        if (r) return 17'd0;
        return 17'(int'(x) + int'(y));
    endfunction

    // One clock: drive on the falling edge, compare one step after the rising edge.
    task automatic step(input logic r, input logic [15:0] x, input logic [15:0] y, input string tag);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
        check(tag, {carry, s}, ref_sum(r, x, y));
    endtask

    logic [15:0] ra;
    logic [15:0] rb;
    logic        rr;
    logic [16:0] held;

    initial begin
        rst = 1'b1;
        a   = 16'hFFFF;
        b   = 16'h0001;

        step(1'b1, 16'hFFFF, 16'h0001, "reset_0");
        step(1'b1, 16'hFFFF, 16'h0001, "reset_1");
        step(1'b0, 16'hFFFF, 16'h0001, "reset_release");

        step(1'b0, 16'h7FFF, 16'h0001, "carry_into_msb");
        step(1'b0, 16'd65000, 16'd536, "wrap_to_zero");
        step(1'b0, 16'hFFFF, 16'hFFFF, "max_plus_max");
        step(1'b0, 16'h0000, 16'h0000, "zero_plus_zero");
        step(1'b0, 16'h8000, 16'h8000, "msb_plus_msb");
        step(1'b0, 16'h5555, 16'hAAAA, "alternating");
        step(1'b0, 16'hAAAA, 16'h5556, "alternating_carry");
        step(1'b0, 16'h00FF, 16'h0001, "byte_ripple");

        // Asserting rst between edges must not disturb the registered outputs.
        step(1'b0, 16'h1234, 16'h4321, "pre_async_probe");
        held = ref_sum(1'b0, 16'h1234, 16'h4321);
        @(negedge clk);
        rst = 1'b1;
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        #2;
        check("mid_cycle_rst_hold", {carry, s}, held);
        @(posedge clk);
        #1;
        check("mid_cycle_rst_edge", {carry, s}, 17'd0);
        step(1'b0, 16'hFFFF, 16'hFFFF, "post_rst_resume");

        for (int i = 0; i < 48; i++) begin
            for (int j = 0; j < 48; j++) begin
                step(1'b0, 16'(i), 16'(j), "exhaustive_low");
            end
        end

        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step(1'b0, ra, rb, "random");
        end

        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = (i % 37 == 19);
            step(rr, ra, rb, rr ? "stream_rst_edge" : "stream");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
